// File: rtl/parity_pkg.sv
// Shared definitions for the framed parity transmitter: FSM encoding and frame-length helper.
package parity_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } tx_state_e;

    localparam int DEF_DATA_W       = 8;
    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_STOP_BITS    = 1;

    // Clocks from the accept edge to the end of the last stop bit.
    function automatic int frame_clks(input int data_w, input int clks_per_bit, input int stop_bits);
        return (2 + data_w + stop_bits) * clks_per_bit;
    endfunction

    localparam int FRAME_CLKS = frame_clks(DEF_DATA_W, DEF_CLKS_PER_BIT, DEF_STOP_BITS);

endpackage

// File: rtl/parity_frame_tx_if.sv
// Word-input handshake: a word moves on any rising edge where in_valid && in_ready;
// d_in/parity must be stable while in_valid is high, and in_valid has no effect otherwise.
interface parity_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] d_in;
    logic              parity;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output d_in,
        output parity,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  d_in,
        input  parity,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/parity_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the terminal and penultimate counts.
module parity_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick,
    output logic pre_tick
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // pre_tick lets the parent register a pulse that lines up with the tick cycle.
    assign tick     = (cnt == LAST);
    assign pre_tick = (cnt == PRE);
endmodule

// File: rtl/parity_frame_tx.sv
// Serialises a data word plus its externally generated parity bit as
// start, LSB-first data, parity, stop bit(s) on an idle-high line.
module parity_frame_tx
    import parity_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic               clk,
    input  logic               rst,
    parity_frame_tx_if.slave   bus,
    output logic               tx,
    output logic               busy,
    output logic               frame_done,
    output tx_state_e          dbg_state
);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              par_q, par_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              tx_q, tx_d;
    logic              in_ready_q, busy_q, done_q, done_d;
    logic              accept, clear, tick, pre_tick;

    parity_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    assign accept = bus.in_valid && in_ready_q;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        bit_d   = bit_q;
        done_d  = 1'b0;
        clear   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    shreg_d = bus.d_in;
                    par_d   = bus.parity;
                    bit_d   = '0;
                    clear   = 1'b1;
                end
            end
            START: begin
                if (tick) state_d = DATA;
            end
            DATA: begin
                if (tick) begin
                    if (bit_q == LAST_BIT) begin
                        state_d = PAR;
                        bit_d   = '0;
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
                    end
                end
            end
            PAR: begin
                if (tick) state_d = STOP;
            end
            STOP: begin
                // The bit counter is reused to count stop bits.
                done_d = (bit_q == LAST_STOP) && pre_tick;
                if (tick) begin
                    if (bit_q == LAST_STOP) begin
                        state_d = IDLE;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The line level is decoded from the next state so tx changes on the same edge.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PAR:     tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            bit_q      <= '0;
            tx_q       <= 1'b1;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            in_ready_q <= (state_d == IDLE);
            busy_q     <= (state_d != IDLE);
            done_q     <= done_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign tx           = tx_q;
    assign busy         = busy_q;
    assign frame_done   = done_q;
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_parity_frame_tx.sv
// Bench for parity_frame_tx: a 1-stop-bit and a 2-stop-bit instance at 4 clks per bit,
// with a frame scoreboard fed by the driver and drained by a mid-bit line sampler.
module tb_parity_frame_tx;
    import parity_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic [7:0]  d_drv = 8'h00;
    logic        p_drv = 1'b0;
    logic        v1 = 1'b0;
    logic        v2 = 1'b0;
    int          dut_sel = 1;
    logic [11:0] exp_q[$];

    logic tx1, busy1, done1, tx2, busy2, done2;
    tx_state_e st1, st2;
    logic m_tx, m_rdy, m_busy, m_done;

    parity_frame_tx_if #(.DATA_W(8)) bus1 ();
    parity_frame_tx_if #(.DATA_W(8)) bus2 ();

    assign bus1.d_in     = d_drv;
    assign bus1.parity   = p_drv;
    assign bus1.in_valid = v1;
    assign bus2.d_in     = d_drv;
    assign bus2.parity   = p_drv;
    assign bus2.in_valid = v2;

    parity_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1.slave),
        .tx (tx1), .busy (busy1), .frame_done (done1), .dbg_state (st1)
    );

    parity_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2.slave),
        .tx (tx2), .busy (busy2), .frame_done (done2), .dbg_state (st2)
    );

    assign m_tx   = (dut_sel == 2) ? tx2 : tx1;
    assign m_rdy  = (dut_sel == 2) ? bus2.in_ready : bus1.in_ready;
    assign m_busy = (dut_sel == 2) ? busy2 : busy1;
    assign m_done = (dut_sel == 2) ? done2 : done1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic send(input logic [7:0] d, input bit hold);
        int t;
        exp_q.push_back({2'b11, ^d, d, 1'b0});
        d_drv = d;
        p_drv = ^d;
        if (dut_sel == 2) v2 = 1'b1; else v1 = 1'b1;
        t = 0;
        while (m_rdy !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (m_rdy !== 1'b1) begin
            $display("FAIL send_ready: in_ready=%b after %0d cycles, want 1", m_rdy, t);
            bad++;
        end
        @(negedge clk);
        if (!hold) begin
            v1 = 1'b0;
            v2 = 1'b0;
        end
    endtask

    task automatic rx_frame(input string name, output int start_cyc);
        logic [11:0] got, exp;
        int t, nb;
        nb = (dut_sel == 2) ? 12 : 11;
        got = '1;
        t = 0;
        start_cyc = -1;
        while (m_tx !== 1'b0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (m_tx !== 1'b0) begin
            $display("FAIL %s start: tx=%b after %0d cycles, want 0", name, m_tx, t);
            bad++;
            return;
        end
        start_cyc = cyc;
        total++;
        if (m_busy !== 1'b1) begin
            $display("FAIL %s busy_start: busy=%b want 1", name, m_busy);
            bad++;
        end
        @(negedge clk);
        got[0] = m_tx;
        for (int b = 1; b < nb; b++) begin
            repeat (4) @(negedge clk);
            got[b] = m_tx;
        end
        @(negedge clk);
        total++;
        if (m_done !== 1'b0) begin
            $display("FAIL %s done_early: frame_done=%b want 0", name, m_done);
            bad++;
        end
        @(negedge clk);
        total++;
        if (m_done !== 1'b1 || m_busy !== 1'b1) begin
            $display("FAIL %s done_last: frame_done=%b busy=%b want 1 1", name, m_done, m_busy);
            bad++;
        end
        @(negedge clk);
        total++;
        if (m_done !== 1'b0 || m_busy !== 1'b0 || m_rdy !== 1'b1 || m_tx !== 1'b1) begin
            $display("FAIL %s idle_after: done=%b busy=%b rdy=%b tx=%b want 0 0 1 1",
                     name, m_done, m_busy, m_rdy, m_tx);
            bad++;
        end
        total++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s frame: got=%h but no expected frame queued", name, got);
            bad++;
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                $display("FAIL %s frame: got=%b want=%b", name, got, exp);
                bad++;
            end
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        total++;
        if (tx1 !== 1'b1 || bus1.in_ready !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0 || st1 !== IDLE) begin
            $display("FAIL reset_power_on: tx=%b rdy=%b busy=%b done=%b st=%0d want 1 1 0 0 0",
                     tx1, bus1.in_ready, busy1, done1, st1);
            bad++;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        dut_sel = 1;
        send(8'h55, 0);
        repeat (10) @(negedge clk);
        total++;
        if (busy1 !== 1'b1 || bus1.in_ready !== 1'b0) begin
            $display("FAIL reset_pre: busy=%b rdy=%b want 1 0", busy1, bus1.in_ready);
            bad++;
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (tx1 !== 1'b1 || bus1.in_ready !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0 || st1 !== IDLE) begin
            $display("FAIL reset_mid: tx=%b rdy=%b busy=%b done=%b st=%0d want 1 1 0 0 0",
                     tx1, bus1.in_ready, busy1, done1, st1);
            bad++;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_frame_01();
        int s;
        dut_sel = 1;
        fork
            send(8'h01, 0);
            rx_frame("frame_01", s);
        join
        repeat (3) @(negedge clk);
    endtask

    task automatic test_frame_ff();
        int s, n, t;
        dut_sel = 1;
        n = 0;
        fork
            send(8'hFF, 0);
            rx_frame("frame_ff", s);
            begin
                t = 0;
                while (busy1 !== 1'b1 && t < 300) begin @(negedge clk); t++; end
                while (busy1 === 1'b1 && n < 300) begin @(negedge clk); n++; end
            end
        join
        total++;
        if (n != 44) begin
            $display("FAIL busy_len: busy high %0d clks, want 44", n);
            bad++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int s1, s2;
        dut_sel = 1;
        fork
            begin
                send(8'hAA, 1);
                send(8'hEC, 0);
            end
            begin
                rx_frame("b2b_aa", s1);
                rx_frame("b2b_ec", s2);
            end
        join
        total++;
        if (s2 - s1 != 45) begin
            $display("FAIL b2b_spacing: starts %0d clks apart, want 45", s2 - s1);
            bad++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_mid_frame_inputs();
        int s, quiet;
        dut_sel = 1;
        fork
            begin
                send(8'h3C, 0);
                repeat (8) @(negedge clk);
                d_drv = 8'h0F;
                p_drv = 1'b0;
                v1 = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    total++;
                    if (bus1.in_ready !== 1'b0) begin
                        $display("FAIL mid_ready: in_ready=%b want 0 at step %0d", bus1.in_ready, i);
                        bad++;
                    end
                end
                v1 = 1'b0;
            end
            rx_frame("mid_frame_3c", s);
        join
        quiet = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx1 !== 1'b1 || busy1 !== 1'b0) quiet = 0;
        end
        total++;
        if (quiet != 1 || exp_q.size() != 0) begin
            $display("FAIL mid_no_accept: line_quiet=%0d queued=%0d want 1 0", quiet, exp_q.size());
            bad++;
        end
    endtask

    task automatic test_two_stop_bits();
        int s;
        dut_sel = 2;
        fork
            send(8'h81, 0);
            rx_frame("stop2_81", s);
        join
        dut_sel = 1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_frame_01();
        test_frame_ff();
        test_back_to_back();
        test_mid_frame_inputs();
        test_two_stop_bits();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
